// File: rtl/cla_seq_pkg.sv
// Shared types and constants for the nibble-serial CLA add/subtract sequencer.
// Holds the controller state encoding and the nibble-count helper.
package cla_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int NIB_W = 4;

  function automatic int nib_count(input int width);
    return width / NIB_W;
  endfunction

endpackage

// File: rtl/cla_seq_ctrl_slice.sv
// Purely combinational 4-bit carry-lookahead adder slice.
// The sequencer time-shares a single instance of it across all nibbles.
module cla4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Every carry is flattened from g/p/ci so no carry ripples bit to bit.
  assign c[0] = ci;
  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & ci);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & ci);

  assign s  = p ^ c[3:0];
  assign co = c[4];

endmodule

// File: rtl/cla_seq_ctrl.sv
// Multi-cycle WIDTH-bit add/subtract built from one shared 4-bit CLA slice,
// processing one nibble per clock LSB first with a registered inter-nibble carry.
module cla_seq_ctrl
  import cla_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NIB   = nib_count(WIDTH);
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

  if (((WIDTH % NIB_W) != 0) || (WIDTH < NIB_W)) begin : g_bad_width
    $error("cla_seq_ctrl: WIDTH must be a positive multiple of 4");
  end

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic               done_q, done_d;

  logic [NIB_W-1:0]   slice_a;
  logic [NIB_W-1:0]   slice_b;
  logic [NIB_W-1:0]   slice_s;
  logic               slice_co;
  logic               last_step;

  cla4_slice u_slice (
    .a  (slice_a),
    .b  (slice_b),
    .ci (carry_q),
    .s  (slice_s),
    .co (slice_co)
  );

  // Loop-based nibble mux keeps every part-select constant after unrolling.
  always_comb begin
    slice_a = '0;
    slice_b = '0;
    for (int k = 0; k < NIB; k++) begin
      if (idx_q == IDX_W'(k)) begin
        slice_a = a_q[k*NIB_W +: NIB_W];
        slice_b = b_q[k*NIB_W +: NIB_W];
      end
    end
  end

  assign last_step = (idx_q == IDX_W'(NIB - 1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          // Subtraction is a + ~b + 1, so b is stored pre-inverted.
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          sum_d   = '0;
          idx_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        for (int k = 0; k < NIB; k++) begin
          if (idx_q == IDX_W'(k)) begin
            sum_d[k*NIB_W +: NIB_W] = slice_s;
          end
        end
        carry_d = slice_co;
        idx_d   = idx_q + IDX_W'(1);
        if (last_step) begin
          cout_d  = slice_co;
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                    (slice_s[NIB_W-1] != a_q[WIDTH-1]);
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign ready = (state_q == ST_IDLE);
  assign busy  = (state_q == ST_RUN);
  assign done  = done_q;
  assign sum   = sum_q;
  assign cout  = cout_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_cla_seq_ctrl.sv
// Directed bench for cla_seq_ctrl: table of hand-computed add/sub vectors on a
// 16-bit build plus start-spam, async-reset-abort and 4-bit build sequences.
module tb_cla_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, sub, cin;
  logic [15:0] a, b;
  logic        ready, busy, done, cout, ovf;
  logic [15:0] sum;

  logic        start4, sub4, cin4;
  logic [3:0]  a4, b4;
  logic        ready4, busy4, done4, cout4, ovf4;
  logic [3:0]  sum4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cla_seq_ctrl #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
    .ready(ready), .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  cla_seq_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .sub(sub4), .a(a4), .b(b4), .cin(cin4),
    .ready(ready4), .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
  );

  typedef struct {
    logic        sub;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] exp_sum;
    logic        exp_cout;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_ready(input string name);
    int cyc = 0;
    while (!ready && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({name, ".ready"}, 32'(ready), 32'd1);
  endtask

  // Waits for done after an accept edge; returns the number of edges taken.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic run_op(input string name, input vec_t v);
    int cyc;
    wait_ready(name);
    sub = v.sub; a = v.a; b = v.b; cin = v.cin; start = 1'b1;
    @(posedge clk); #1;
    // Operands become don't-care once accepted; scramble them.
    start = 1'b0; a = ~v.a; b = ~v.b; cin = ~v.cin; sub = ~v.sub;
    check({name, ".busy"}, 32'(busy), 32'd1);
    wait_done(cyc);
    check({name, ".latency"}, 32'(cyc), 32'd4);
    check({name, ".sum"}, 32'(sum), 32'(v.exp_sum));
    check({name, ".cout"}, 32'(cout), 32'(v.exp_cout));
    check({name, ".ovf"}, 32'(ovf), 32'(v.exp_ovf));
    check({name, ".ready_in_done"}, 32'(ready), 32'd0);
    @(posedge clk); #1;
    check({name, ".done_width"}, 32'(done), 32'd0);
    check({name, ".ready_after"}, 32'(ready), 32'd1);
    @(posedge clk); #1;
    check({name, ".sum_hold"}, 32'(sum), 32'(v.exp_sum));
    $display("op %s sub=%0d a=%h b=%h cin=%0d -> sum=%h cout=%0d ovf=%0d latency=%0d",
             name, v.sub, v.a, v.b, v.cin, sum, cout, ovf, cyc);
  endtask

  initial begin
    int cyc;
    int dones;
    vec_t fresh;

    vecs[0] = '{1'b0, 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[4] = '{1'b1, 16'h0003, 16'h0005, 1'b0, 16'hFFFE, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 16'h1234, 16'h0001, 1'b1, 16'h1236, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[7] = '{1'b1, 16'h5555, 16'h5555, 1'b0, 16'h0000, 1'b1, 1'b0};

    rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
    start4 = 1'b0; sub4 = 1'b0; cin4 = 1'b0; a4 = '0; b4 = '0;
    #12;
    check("reset.ready", 32'(ready), 32'd1);
    check("reset.busy", 32'(busy), 32'd0);
    check("reset.done", 32'(done), 32'd0);
    check("reset.sum", 32'(sum), 32'd0);
    check("reset.cout_ovf", {30'd0, cout, ovf}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i]);
    end

    // start held high through RUN/DONE with changing operands.
    wait_ready("spam");
    sub = 1'b0; a = 16'h1234; b = 16'h0FFF; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    dones = 0;
    for (int i = 1; i <= 4; i++) begin
      a = 16'(16'h1111 * i); b = 16'h0F0F; sub = i[0]; cin = 1'b1;
      @(posedge clk); #1;
      if (done) dones++;
    end
    check("spam.done_at_E4", 32'(done), 32'd1);
    check("spam.sum_first", 32'(sum), 32'h2233);
    sub = 1'b0; a = 16'h0101; b = 16'h0202; cin = 1'b0;
    @(posedge clk); #1;
    check("spam.ready_returns", 32'(ready), 32'd1);
    check("spam.no_accept_in_done", 32'(busy), 32'd0);
    @(posedge clk); #1;
    check("spam.second_accept", 32'(busy), 32'd1);
    start = 1'b0; a = 16'hDEAD; b = 16'hBEEF;
    wait_done(cyc);
    check("spam.done_count", 32'(dones), 32'd1);
    check("spam.second_latency", 32'(cyc), 32'd4);
    check("spam.second_sum", 32'(sum), 32'h0303);
    $display("op spam first=2233 second sum=%h dones_first=%0d", sum, dones);
    @(posedge clk); #1;

    // Asynchronous reset two nibbles into a request.
    wait_ready("abort");
    sub = 1'b0; a = 16'h1234; b = 16'h0FFF; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort.partial_sum", 32'(sum), 32'h0033);
    #2 rst = 1'b1;
    #1;
    check("abort.sum", 32'(sum), 32'd0);
    check("abort.flags", {28'd0, ready, busy, done, cout | ovf}, 32'b1000);
    @(posedge clk); #2 rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check("abort.no_done", 32'(dones), 32'd0);
    $display("op abort partial=0033 dones_after_reset=%0d", dones);
    fresh = '{1'b0, 16'hA5A5, 16'h1111, 1'b1, 16'hB6B7, 1'b0, 1'b0};
    run_op("fresh", fresh);

    // WIDTH=4 build: single RUN cycle.
    a4 = 4'h9; b4 = 4'h8; cin4 = 1'b1; sub4 = 1'b0; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0; a4 = 4'h0; b4 = 4'h0;
    check("w4.busy", 32'(busy4), 32'd1);
    check("w4.no_early_done", 32'(done4), 32'd0);
    @(posedge clk); #1;
    check("w4.done", 32'(done4), 32'd1);
    check("w4.sum", 32'(sum4), 32'h2);
    check("w4.cout_ovf", {30'd0, cout4, ovf4}, 32'b11);
    $display("op w4 add a=9 b=8 cin=1 -> sum=%h cout=%0d ovf=%0d", sum4, cout4, ovf4);
    @(posedge clk); #1;
    check("w4.done_width", 32'(done4), 32'd0);
    check("w4.ready", 32'(ready4), 32'd1);
    a4 = 4'h3; b4 = 4'h5; cin4 = 1'b0; sub4 = 1'b1; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    @(posedge clk); #1;
    check("w4sub.done", 32'(done4), 32'd1);
    check("w4sub.sum", 32'(sum4), 32'hE);
    check("w4sub.cout_ovf", {30'd0, cout4, ovf4}, 32'b00);
    $display("op w4 sub a=3 b=5 -> sum=%h cout=%0d ovf=%0d", sum4, cout4, ovf4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
